// File: rtl/fw_seq_pkg.sv
// fw_seq_pkg: state encoding and sizing helper shared by fw_sequencer and its counter.
package fw_seq_pkg;

    localparam int FW_SEQ_SW = 3;

    typedef enum logic [FW_SEQ_SW-1:0] {
        ST_IDLE         = 3'd0,
        ST_AVERAGING    = 3'd1,
        ST_LAYER_START  = 3'd2,
        ST_LAYER_WAIT   = 3'd3,
        ST_ARGMAX_START = 3'd4,
        ST_ARGMAX_WAIT  = 3'd5,
        ST_DONE         = 3'd6,
        ST_ERROR        = 3'd7
    } fw_seq_state_t;

    function automatic int fw_seq_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// seq_cycle_counter: up-counter with synchronous clear/enable and a terminal-count flag.
module seq_cycle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tc = (r_cnt == i_term);

endmodule

// File: rtl/fw_sequencer.sv
// fw_sequencer: averaging -> NUM_LAYERS MLP layer handshakes -> argmax -> fw_done, Moore outputs.
// Optional per-wait-state watchdog enabled by defining FW_SEQ_WATCHDOG_EN.
module fw_sequencer
    import fw_seq_pkg::*;
#(
    parameter int   NUM_LAYERS     = 2,
    parameter int   AVG_CYCLES     = 4,
    parameter int   TIMEOUT_CYCLES = 1024,
    localparam int  LW             = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fw_go,
    input  logic          fw_abort,
    input  logic          layer_done,
    input  logic          argmax_done,
    output logic          avg_en,
    output logic          layer_go,
    output logic [LW-1:0] layer_idx,
    output logic          argmax_go,
    output logic          busy,
    output logic          fw_done,
    output logic          fw_error
);

    localparam int             CW         = $clog2(fw_seq_max(AVG_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [CW-1:0]  AVG_TERM   = CW'(AVG_CYCLES - 1);
    localparam logic [LW-1:0]  LAST_LAYER = LW'(NUM_LAYERS - 1);

    fw_seq_state_t r_state;
    fw_seq_state_t w_next;
    logic [LW-1:0] r_layer;
    logic          w_cnt_en;
    logic          w_cnt_clr;
    logic          w_tc;
    logic [CW-1:0] w_term;

    // One counter serves both the averaging window and the wait-state watchdog;
    // it is held at zero in every other state so each use starts from 0.
`ifdef FW_SEQ_WATCHDOG_EN
    localparam logic [CW-1:0] TMO_TERM = CW'(TIMEOUT_CYCLES - 1);
    logic w_in_wait;
    assign w_in_wait = (r_state == ST_LAYER_WAIT) || (r_state == ST_ARGMAX_WAIT);
    assign w_cnt_en  = (r_state == ST_AVERAGING) || w_in_wait;
    assign w_term    = (r_state == ST_AVERAGING) ? AVG_TERM : TMO_TERM;
`else
    assign w_cnt_en  = (r_state == ST_AVERAGING);
    assign w_term    = AVG_TERM;
`endif
    assign w_cnt_clr = !w_cnt_en;

    seq_cycle_counter #(
        .W(CW)
    ) u_cnt (
        .clk    (clk),
        .rst    (reset),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .i_term (w_term),
        .o_tc   (w_tc)
    );

    always_comb begin
        w_next = r_state;
        if (fw_abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:         if (fw_go) w_next = ST_AVERAGING;
                ST_AVERAGING:    if (w_tc) w_next = ST_LAYER_START;
                ST_LAYER_START:  w_next = ST_LAYER_WAIT;
                ST_LAYER_WAIT: begin
                    if (layer_done)
                        w_next = (r_layer == LAST_LAYER) ? ST_ARGMAX_START : ST_LAYER_START;
`ifdef FW_SEQ_WATCHDOG_EN
                    else if (w_tc)
                        w_next = ST_ERROR;
`endif
                end
                ST_ARGMAX_START: w_next = ST_ARGMAX_WAIT;
                ST_ARGMAX_WAIT: begin
                    if (argmax_done)
                        w_next = ST_DONE;
`ifdef FW_SEQ_WATCHDOG_EN
                    else if (w_tc)
                        w_next = ST_ERROR;
`endif
                end
                default:         w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_layer <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_next == ST_AVERAGING)
                r_layer <= '0;
            else if (r_state == ST_LAYER_WAIT && w_next == ST_LAYER_START)
                r_layer <= r_layer + LW'(1);
        end
    end

    assign avg_en    = (r_state == ST_AVERAGING);
    assign layer_go  = (r_state == ST_LAYER_START);
    assign layer_idx = (r_state == ST_LAYER_START || r_state == ST_LAYER_WAIT) ? r_layer : '0;
    assign argmax_go = (r_state == ST_ARGMAX_START);
    assign busy      = (r_state != ST_IDLE);
    assign fw_done   = (r_state == ST_DONE);
`ifdef FW_SEQ_WATCHDOG_EN
    assign fw_error  = (r_state == ST_ERROR);
`else
    assign fw_error  = 1'b0;
`endif

endmodule

// File: doc/fw_sequencer.md
# fw_sequencer

Parametrised forward-pass controller for the digit-recognition datapath. On `fw_go` it runs an averaging window of configurable length, then sequences a configurable number of MLP layers through a per-layer go/done handshake, then an argmax stage, and finally pulses `fw_done`. It also supports abort and an optional watchdog. It sits between the top-level control FSM and the averaging/MLP/argmax datapath blocks.

## Interface
- `NUM_LAYERS`, default 2: number of MLP layers to sequence; must be ≥ 1.
- `AVG_CYCLES`, default 4: cycles `avg_en` is held high; must be ≥ 1.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit per wait state; only used with `FW_SEQ_WATCHDOG_EN`.
- `LW`, derived: `max(1, $clog2(NUM_LAYERS))`, the width of `layer_idx`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; all state and outputs clear immediately.
- `fw_go` in 1: start request, sampled only in IDLE.
- `fw_abort` in 1: returns to IDLE next cycle from any state.
- `layer_done` in 1: current layer finished; sampled only in LAYER_WAIT.
- `argmax_done` in 1: argmax finished; sampled only in ARGMAX_WAIT.
- `avg_en` out 1: high throughout AVERAGING.
- `layer_go` out 1: one-cycle pulse in LAYER_START.
- `layer_idx` out LW: index of the current layer; 0 outside the layer states.
- `argmax_go` out 1: one-cycle pulse in ARGMAX_START.
- `busy` out 1: high in every state except IDLE.
- `fw_done` out 1: one-cycle pulse in DONE.
- `fw_error` out 1: one-cycle pulse in ERROR; constant 0 without the macro.

## Operation
- States: IDLE, AVERAGING, LAYER_START, LAYER_WAIT, ARGMAX_START, ARGMAX_WAIT, DONE, ERROR. ERROR exists only with the macro.
- Transitions:
  - IDLE → AVERAGING on `fw_go`; layer counter and cycle counter cleared.
  - AVERAGING → LAYER_START after exactly AVG_CYCLES cycles.
  - LAYER_START → LAYER_WAIT unconditionally.
  - LAYER_WAIT → LAYER_START with the layer counter incremented, on `layer_done` when `layer_idx < NUM_LAYERS-1`.
  - LAYER_WAIT → ARGMAX_START on `layer_done` when `layer_idx == NUM_LAYERS-1`.
  - ARGMAX_START → ARGMAX_WAIT unconditionally.
  - ARGMAX_WAIT → DONE on `argmax_done`.
  - DONE → IDLE unconditionally.
  - ERROR → IDLE unconditionally.
- Outputs are Moore: decoded from registered state and counters only, with no combinational input-to-output path.
- Reset value of every output is 0. State resets to IDLE and the layer counter to 0.
- Boundary rules:
  - `fw_go` while busy: ignored, not queued.
  - `fw_go` in the same cycle as DONE: ignored. The new run needs `fw_go` in IDLE.
  - `layer_done` or `argmax_done` outside its wait state: ignored.
  - `fw_abort` has priority over every other input, including a same-cycle done or timeout. Next state is IDLE with no `fw_done` and no `fw_error`.
  - `fw_abort` in IDLE: no effect; `fw_go` in the same cycle is ignored.
  - NUM_LAYERS = 1: a single LAYER_START/LAYER_WAIT pass with `layer_idx` = 0.

## Timing
- Reference point: `fw_go` sampled in IDLE at cycle 0.
- AVERAGING occupies cycles 1..A, where A = AVG_CYCLES.
- Layer k has LAYER_START at cycle A+1+2k.
- Earliest accepted `layer_done` is the cycle after `layer_go`.
- With every done asserted at its earliest opportunity:
  - ARGMAX_START is at A+2L+1, where L = NUM_LAYERS.
  - ARGMAX_WAIT is at A+2L+2.
  - `fw_done` is at A+2L+3.
- Each additional wait cycle before a done adds one cycle of latency.
- Reset mid-run: outputs drop asynchronously, with no done or error pulse.

## Configuration
- Macro: `FW_SEQ_WATCHDOG_EN`.
- Defined:
  - The cycle counter is cleared on entry to LAYER_WAIT or ARGMAX_WAIT and increments each cycle in those states.
  - If it reaches TIMEOUT_CYCLES without the matching done, next state is ERROR.
  - `fw_error` pulses for one cycle and the block then returns to IDLE.
  - A done in the same cycle as the timeout wins.
- Undefined:
  - Wait states wait indefinitely.
  - `fw_error` is tied to 0 and TIMEOUT_CYCLES is ignored.

## Structure
- Package `fw_seq_pkg`: state enum `fw_seq_state_t` and state-width constant.
- The cycle counter is shared between AVERAGING and the watchdog. Its width is `$clog2(max(AVG_CYCLES, TIMEOUT_CYCLES)+1)`.
- Sub-module `seq_cycle_counter`: clear/enable counter with terminal-count compare. It is instantiated once.

## Test plan
- A=4, L=3; dones asserted at their earliest cycle; `fw_go` at cycle 0 → `avg_en` high cycles 1–4; `layer_go` at 5, 7, 9 with `layer_idx` 0, 1, 2; `argmax_go` at 11; `fw_done` at 13.
- Delay `layer_done` for layer 1 by 10 cycles → `fw_done` at 23; `fw_go` pulses during the run are ignored; `busy` is high cycles 1–23.
- `fw_abort` asserted in the same cycle as `layer_done` in LAYER_WAIT → IDLE next cycle; no `fw_done`; `busy` drops.
- With the macro, TIMEOUT_CYCLES=8 and `argmax_done` never asserted → `fw_error` pulses 8 cycles after ARGMAX_WAIT entry, then IDLE.
- Async `reset` mid-AVERAGING → all outputs 0 immediately; a fresh `fw_go` gives the full nominal sequence.
- L=1, A=1 → `layer_go` at 2 with `layer_idx` 0; `fw_done` at 6.
